alu_exec_unit: RTL and testbench

Multi-cycle execute unit that consumes the 3-bit ALUControl code produced by the control unit's ALU decoder and performs the encoded operation on two operands.
- Single-cycle ops (add/sub/and/or/slt) complete in one cycle.
- Shifts and multiply run iteratively.
- Sits between register-read and writeback, with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_iter_engine.sv | 64 ++++++
 rtl/alu_exec_unit.sv | 110 +++++++++++
 tb/tb_alu_exec_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execute-unit FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_MUL   = 2'b10,
    S_DONE  = 2'b11
  } alu_state_e;

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative datapath: one shift position or one multiplier bit per cycle.
module alu_iter_engine #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_mul,
  input  logic               shift_right,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] step_acc, step_a, step_b;
  logic [SHAMT_W:0] cnt;
  logic             mode_mul, mode_right;

  always_comb begin
    step_acc = acc;
    step_a   = opa;
    step_b   = opb;
    if (mode_mul) begin
      if (opb[0]) step_acc = acc + opa;
      step_a = opa << 1;
      step_b = opb >> 1;
    end else begin
      step_a = mode_right ? (opa >> 1) : (opa << 1);
    end
  end

  // The final step's value is presented combinationally so the owner can
  // register it on the same edge the counter expires.
  assign done   = (cnt == (SHAMT_W+1)'(1));
  assign result = mode_mul ? step_acc : step_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      cnt        <= '0;
      mode_mul   <= 1'b0;
      mode_right <= 1'b0;
    end else if (start) begin
      acc        <= '0;
      opa        <= a;
      opb        <= b;
      cnt        <= is_mul ? (SHAMT_W+1)'(WIDTH) : {1'b0, shamt};
      mode_mul   <= is_mul;
      mode_right <= shift_right;
    end else if (cnt != '0) begin
      acc <= step_acc;
      opa <= step_a;
      opb <= step_b;
      cnt <= cnt - (SHAMT_W+1)'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: handshakes, FSM, single-cycle ops, result registers.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  alu_state_e state, state_next;

  logic [SHAMT_W-1:0] shamt;
  logic               accept, is_shift, is_mul, eng_start, eng_done, load_out;
  logic [WIDTH-1:0]   fast_res, eng_res, fin_res;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = SrcB[SHAMT_W-1:0];
  assign is_shift  = (ALUControl == ALU_SLL) || (ALUControl == ALU_SRL);
  assign is_mul    = (ALUControl == ALU_MUL);
  assign eng_start = accept && (is_mul || (is_shift && shamt != '0));

  alu_iter_engine #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_iter (
    .clk         (clk),
    .rst         (rst),
    .start       (eng_start),
    .is_mul      (is_mul),
    .shift_right (ALUControl == ALU_SRL),
    .a           (SrcA),
    .b           (SrcB),
    .shamt       (shamt),
    .done        (eng_done),
    .result      (eng_res)
  );

  always_comb begin
    fast_res = '0;
    case (ALUControl)
      ALU_ADD: fast_res = SrcA + SrcB;
      ALU_SUB: fast_res = SrcA - SrcB;
      ALU_AND: fast_res = SrcA & SrcB;
      ALU_OR:  fast_res = SrcA | SrcB;
      ALU_SLT: fast_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLL: fast_res = SrcA;   // only reached here with a zero shift amount
      ALU_SRL: fast_res = SrcA;
      default: fast_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    fin_res    = eng_res;
    case (state)
      S_IDLE: begin
        fin_res = fast_res;
        if (accept) begin
          if (is_mul) begin
            state_next = S_MUL;
          end else if (is_shift && shamt != '0) begin
            state_next = S_SHIFT;
          end else begin
            state_next = S_DONE;
            load_out   = 1'b1;
          end
        end
      end
      S_SHIFT, S_MUL: begin
        if (eng_done) begin
          state_next = S_DONE;
          load_out   = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      state <= state_next;
      if (load_out) begin
        ALUResult <= fin_res;
        Zero      <= (fin_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: latency/result model plus directed vectors.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, Zero;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB, ALUResult;

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the operation computes and how many cycles until valid.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b010: return a + b;
      3'b110: return a - b;
      3'b000: return a & b;
      3'b001: return a | b;
      3'b111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: return a * b;
      3'b100: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
    if (op == 3'b011) return 33;
    if (op == 3'b100 || op == 3'b101) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  logic        m_valid = 1'b0;
  logic        m_zero  = 1'b0;
  logic [31:0] m_res   = '0;
  logic [31:0] m_pend  = '0;
  int          m_wait  = 0;
  logic        m_ready;
  assign m_ready = !m_valid && (m_wait == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_res   <= '0;
      m_zero  <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_wait > 1) begin
      m_wait <= m_wait - 1;
    end else if (m_wait == 1) begin
      m_wait  <= 0;
      m_valid <= 1'b1;
      m_res   <= m_pend;
      m_zero  <= (m_pend == 32'd0);
    end else if (in_valid) begin
      m_pend <= ref_alu(ALUControl, SrcA, SrcB);
      if (ref_lat(ALUControl, SrcB) == 1) begin
        m_valid <= 1'b1;
        m_res   <= ref_alu(ALUControl, SrcA, SrcB);
        m_zero  <= (ref_alu(ALUControl, SrcA, SrcB) == 32'd0);
      end else begin
        m_wait <= ref_lat(ALUControl, SrcB) - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_in_ready", in_ready, m_ready);
      chk("cmp_out_valid", out_valid, m_valid);
      chk("cmp_result", ALUResult, m_res);
      chk("cmp_zero", Zero, m_zero);
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit noise, input int hold);
    int cyc;
    logic [31:0] held;
    @(negedge clk);
    chk({name, "_ready"}, in_ready, 1);
    in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom_range(0, 7));
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      chk({name, "_busy_ready"}, in_ready, 0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        ALUControl = 3'($urandom_range(0, 7));
        SrcA = $urandom; SrcB = $urandom;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, cyc, lat);
    chk({name, "_result"}, ALUResult, exp);
    chk({name, "_zero"}, Zero, (exp == 32'd0));
    held = ALUResult;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_result"}, ALUResult, held);
      chk({name, "_hold_ready"}, in_ready, 0);
    end
    // A request offered alongside out_ready in DONE must not be taken.
    out_ready = 1'b1; in_valid = 1'b1; ALUControl = 3'b010; SrcA = 32'd1; SrcB = 32'd1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk({name, "_drop_valid"}, out_valid, 0);
    chk({name, "_back_idle"}, in_ready, 1);
    chk({name, "_kept_result"}, ALUResult, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 3'b000; SrcA = '0; SrcB = '0;
    @(posedge clk);
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", ALUResult, 0);
    chk("reset_zero", Zero, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk_en = 1'b1;

    run_op("add",      3'b010, 32'd5,       32'd7,       32'd12,       1,  1'b0, 0);
    run_op("sub_eq",   3'b110, 32'd9,       32'd9,       32'd0,        1,  1'b0, 0);
    run_op("sub_wrap", 3'b110, 32'd0,       32'd1,       32'hFFFFFFFF, 1,  1'b0, 0);
    run_op("and",      3'b000, 32'hF0F0,    32'hFF00,    32'hF000,     1,  1'b0, 0);
    run_op("or",       3'b001, 32'hF0F0,    32'hFF00,    32'hFFF0,     1,  1'b0, 0);
    run_op("slt_neg",  3'b111, 32'hFFFFFFFF, 32'd1,      32'd1,        1,  1'b0, 0);
    run_op("slt_pos",  3'b111, 32'd1,       32'hFFFFFFFF, 32'd0,       1,  1'b0, 0);
    run_op("mul",      3'b011, 32'd6,       32'd7,       32'd42,       33, 1'b1, 0);
    run_op("mul_wrap", 3'b011, 32'hFFFFFFFF, 32'd2,      32'hFFFFFFFE, 33, 1'b0, 0);
    run_op("sll4",     3'b100, 32'd1,       32'd4,       32'd16,       5,  1'b1, 0);
    run_op("srl31",    3'b101, 32'h80000000, 32'd31,     32'd1,        32, 1'b0, 0);
    run_op("sll0",     3'b100, 32'h1234,    32'd0,       32'h1234,     1,  1'b0, 0);
    run_op("sll_mask", 3'b100, 32'd3,       32'h25,      32'h60,       6,  1'b0, 0);
    run_op("srl_mask", 3'b101, 32'hF000_0000, 32'h24,    32'h0F00_0000, 5, 1'b0, 0);
    run_op("bp_add",   3'b010, 32'h1000,    32'h0234,    32'h1234,     1,  1'b0, 4);
    run_op("after_bp", 3'b110, 32'd100,     32'd1,       32'd99,       1,  1'b0, 0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 3'b011; SrcA = 32'd123; SrcB = 32'd456;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", ALUResult, 0);
    chk("midrst_zero", Zero, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      chk("midrst_no_valid", out_valid, 0);
    end
    run_op("post_rst", 3'b010, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
